sync_fifo_bypass: RTL and testbench
===================================

Name: sync_fifo_bypass

Overview:
- Synchronous FIFO with an arbiter handshake and a zero-storage bypass path.
- Sits between a data producer and a shared-resource arbiter.
- Requests access via o_Grant and drains data when the arbiter returns i_Grant.
- When the FIFO is empty and the grant is already present, write data goes straight to the output register (1-cycle latency). Otherwise it is buffered and drained in order.

Parameters:
- DEPTH, 8, number of FIFO entries; power of two, >= 2.
- WIDTH, 8, data word width in bits.

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- i_WrEn  input  1  write strobe; i_WrData is valid this cycle.
- i_WrData  input  WIDTH  write data.
- i_Grant  input  1  arbiter grant; the block may emit one word this cycle.
- o_Valid  output  1  o_Data holds a delivered word this cycle.
- o_Data  output  WIDTH  delivered data word (registered).
- o_Grant  output  1  request to arbiter (combinational).

Behaviour:
- State:
  - memory of DEPTH x WIDTH;
  - wr_ptr and rd_ptr, log2(DEPTH) bits each, wrapping modulo DEPTH;
  - count, log2(DEPTH)+1 bits;
  - empty = (count==0), full = (count==DEPTH).
- Reset (asynchronous):
  - pointers, count, o_Valid and o_Data clear to 0;
  - memory contents are not reset;
  - reset mid-operation discards all buffered data.
- o_Grant = i_WrEn | ~empty (combinational).
- i_Grant is ignored while o_Grant is 0.
- Each cycle, exactly one of the following applies:
  - bypass = empty & i_WrEn & i_Grant:
    - o_Data <= i_WrData, o_Valid <= 1;
    - FIFO untouched, count stays 0.
  - pop = ~empty & i_Grant:
    - o_Data <= mem[rd_ptr], o_Valid <= 1;
    - rd_ptr++.
  - neither:
    - o_Valid <= 0;
    - o_Data holds its previous value.
- push = i_WrEn & ~bypass & (~full | pop):
  - mem[wr_ptr] <= i_WrData, wr_ptr++.
- Count update:
  - push & pop: count unchanged;
  - push only: +1;
  - pop only: -1.
- Ordering:
  - output order always equals write order;
  - a new write never overtakes buffered data, because bypass requires empty.
- Full:
  - a write while full with no pop is dropped silently; state is unchanged;
  - a write while full with a pop is accepted.
- Empty boundary:
  - if the last entry pops in the same cycle as a write, the write is pushed (not bypassed) and pops on the next cycle;
  - with grant held, output stays continuous with no bubble.
- Latency:
  - bypass: 1 cycle from write to o_Valid;
  - buffered: 1 cycle from grant to o_Valid;
  - at most one word out per cycle.

Optional Feature:
- Macro BYPASS_PATH_EN.
- Defined (default build): bypass behaves as described above.
- Undefined:
  - bypass is forced to 0, so every write goes through the memory;
  - o_Grant = ~empty;
  - minimum write-to-output latency becomes 2 cycles (push, then pop on the next granted cycle).
- All other rules are unchanged in both builds.

Test Plan:
- Bypass: empty FIFO, i_Grant follows o_Grant, write 1,2,3,4 on consecutive cycles -> o_Data 1,2,3,4 with o_Valid high on each following cycle; count stays 0.
- Buffered: i_Grant=0, write 5,6,7,8 -> o_Valid 0, count=4, o_Grant=1 after the writes end.
- Drain plus new writes: grant re-enabled, write 9,10,11,12 -> 8 consecutive valid outputs 5..12 with no bubble; count returns to 0.
- Empty-boundary continuity: 4 entries buffered, grant on; write 17..20 starting the cycle the FIFO empties -> contiguous outputs through 20, no o_Valid gap, no reordering.
- Full/overflow: i_Grant=0, write 9 words 0..8 -> count=8, word 8 dropped. Then write 0xAA with grant on -> 0xAA accepted, count stays 8.
- Reset mid-stream: assert Reset with 3 entries buffered -> o_Valid=0, o_Data=0, count=0 immediately. After release, a granted write of 0x55 bypasses in 1 cycle.

Source files
------------

// File: rtl/sync_fifo_bypass.sv
// Synchronous FIFO that requests an arbiter slot and drains one word per grant.
// Define BYPASS_PATH_EN to let writes into an empty, granted FIFO skip the memory.
module sync_fifo_bypass #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             i_WrEn,
  input  logic [WIDTH-1:0] i_WrData,
  input  logic             i_Grant,
  output logic             o_Valid,
  output logic [WIDTH-1:0] o_Data,
  output logic             o_Grant
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  logic empty, full, bypass, pop, push;

  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == CW'(DEPTH));
`ifdef BYPASS_PATH_EN
    bypass  = empty & i_WrEn & i_Grant;
    o_Grant = i_WrEn | ~empty;
`else
    bypass  = 1'b0;
    o_Grant = ~empty;
`endif
    // A pop frees a slot this cycle, so a write to a full FIFO is still taken.
    pop  = ~empty & i_Grant;
    push = i_WrEn & ~bypass & (~full | pop);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = 1'b0;
    data_d   = data_q;

    if (bypass) begin
      valid_d = 1'b1;
      data_d  = i_WrData;
    end else if (pop) begin
      valid_d  = 1'b1;
      data_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end

    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
    end
  end

  // Storage has no reset; the pointers alone decide what is live.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_WrData;
    end
  end

  assign o_Valid = valid_q;
  assign o_Data  = data_q;

endmodule

// File: tb/tb_sync_fifo_bypass.sv
// Testbench for sync_fifo_bypass: vector table driven through a behavioural
// occupancy model, with a scoreboard queue holding words awaiting delivery.
module tb_sync_fifo_bypass;

  localparam int DEPTH = 8;
  localparam int WIDTH = 8;
`ifdef BYPASS_PATH_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             Reset;
  logic             i_WrEn;
  logic [WIDTH-1:0] i_WrData;
  logic             i_Grant;
  logic             o_Valid;
  logic [WIDTH-1:0] o_Data;
  logic             o_Grant;

  always #5 CLK = ~CLK;

  sync_fifo_bypass #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .i_WrEn   (i_WrEn),
    .i_WrData (i_WrData),
    .i_Grant  (i_Grant),
    .o_Valid  (o_Valid),
    .o_Data   (o_Data),
    .o_Grant  (o_Grant)
  );

  typedef struct {
    bit               wr;
    logic [WIDTH-1:0] d;
    bit               g;
  } vec_t;

  vec_t             vecs[$];
  logic [WIDTH-1:0] sb[$];
  int               m_count;
  logic [WIDTH-1:0] m_last;
  int               n_vec = 0;
  int               n_err = 0;

  function automatic void add(bit w, logic [WIDTH-1:0] d, bit gg);
    vec_t v;
    v.wr = w;
    v.d  = d;
    v.g  = gg;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(bit w, logic [WIDTH-1:0] d, bit gg);
    bit               emp, byp, pop, push, exp_og, exp_v;
    logic [WIDTH-1:0] exp_d;
    @(negedge CLK);
    i_WrEn   = w;
    i_WrData = d;
    i_Grant  = gg;
    #1;
    emp    = (m_count == 0);
    exp_og = BYP ? (w | !emp) : !emp;
    check("o_Grant", {31'd0, o_Grant}, {31'd0, exp_og});
    byp  = BYP && emp && w && gg;
    pop  = !emp && gg;
    push = w && !byp && ((m_count < DEPTH) || pop);
    if (byp || push) sb.push_back(d);
    if (push && !pop) m_count++;
    else if (pop && !push) m_count--;
    exp_v = byp || pop;
    @(posedge CLK);
    #1;
    check("o_Valid", {31'd0, o_Valid}, {31'd0, exp_v});
    if (exp_v) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL scoreboard: output expected with no word pending (t=%0t)", $time);
      end else begin
        exp_d  = sb.pop_front();
        m_last = exp_d;
        check("o_Data", {24'd0, o_Data}, {24'd0, exp_d});
      end
    end else begin
      check("o_Data_hold", {24'd0, o_Data}, {24'd0, m_last});
    end
    check("count", {28'd0, dut.count_q}, m_count);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    Reset   = 1'b1;
    i_WrEn  = 1'b0;
    i_Grant = 1'b0;
    #1;
    check("rst_o_Valid", {31'd0, o_Valid}, 32'd0);
    check("rst_o_Data", {24'd0, o_Data}, 32'd0);
    check("rst_count", {28'd0, dut.count_q}, 32'd0);
    sb.delete();
    m_count = 0;
    m_last  = '0;
    @(negedge CLK);
    Reset = 1'b0;
  endtask

  initial begin
    Reset    = 1'b1;
    i_WrEn   = 1'b0;
    i_WrData = '0;
    i_Grant  = 1'b0;
    m_count  = 0;
    m_last   = '0;

    // Bypass run: back-to-back granted writes into an empty FIFO.
    for (int i = 1; i <= 4; i++) add(1'b1, 8'(i), 1'b1);
    add(1'b0, 8'h00, 1'b1);
    // Buffered with grant withheld, then drain while writing 9..12.
    for (int i = 5; i <= 8; i++) add(1'b1, 8'(i), 1'b0);
    add(1'b0, 8'h00, 1'b0);
    for (int i = 9; i <= 12; i++) add(1'b1, 8'(i), 1'b1);
    for (int i = 0; i < 5; i++) add(1'b0, 8'h00, 1'b1);
    // Empty boundary: new writes start on the cycle the last entry pops.
    for (int i = 13; i <= 16; i++) add(1'b1, 8'(i), 1'b0);
    for (int i = 0; i < 3; i++) add(1'b0, 8'h00, 1'b1);
    for (int i = 17; i <= 20; i++) add(1'b1, 8'(i), 1'b1);
    for (int i = 0; i < 2; i++) add(1'b0, 8'h00, 1'b1);
    // Overflow: nine writes with no grant, then a write alongside a pop.
    for (int i = 0; i <= 8; i++) add(1'b1, 8'(i), 1'b0);
    add(1'b1, 8'hAA, 1'b1);
    for (int i = 0; i < 10; i++) add(1'b0, 8'h00, 1'b1);

    #2;
    check("init_o_Valid", {31'd0, o_Valid}, 32'd0);
    check("init_o_Data", {24'd0, o_Data}, 32'd0);
    @(negedge CLK);
    Reset = 1'b0;

    foreach (vecs[i]) step(vecs[i].wr, vecs[i].d, vecs[i].g);

    // Reset with three words buffered, then a granted write of 0x55.
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
    check("pre_rst_count", {28'd0, dut.count_q}, 32'd3);
    do_reset();
    step(1'b1, 8'h55, 1'b1);
    if (BYP) check("bypass_after_rst", {24'd0, o_Data}, 32'h55);
    step(1'b0, 8'h00, 1'b1);
    check("post_rst_data", {24'd0, o_Data}, 32'h55);

    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) != 0));
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 8'h00, 1'b1);
    check("final_count", {28'd0, dut.count_q}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
